// File: rtl/aes_pkg.sv
// Shared AES constants, block/word types and word-select helper.
// Used by the output serializer and its block FIFO.
package aes_pkg;

    localparam int AES_BLK_W         = 128;
    localparam int AES_WORD_W        = 32;
    localparam int AES_WORDS_PER_BLK = 4;

    typedef logic [AES_BLK_W-1:0]  aes_blk_t;
    typedef logic [AES_WORD_W-1:0] aes_word_t;

    // Word 0 is the most significant 32 bits of the block
    function automatic aes_word_t blk_word(aes_blk_t b, logic [1:0] idx);
        aes_word_t w;
        unique case (idx)
            2'd0: w = b[127:96];
            2'd1: w = b[95:64];
            2'd2: w = b[63:32];
            2'd3: w = b[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Block FIFO holding DEPTH 128-bit AES results (DEPTH power of two).
// Pointers wrap naturally; full is registered from the next count.
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  aes_blk_t                 wdata,
    output aes_blk_t                 head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    aes_blk_t          mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;

    // Next occupancy; push and pop together leave it unchanged
    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointer, count and full-flag state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    // Block storage; a push at full overwrites the slot being popped
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/aes_out_serializer.sv
// Captures AES result blocks on valid edges and streams them as 32-bit words.
// Optional saturating drop counter enabled by macro AES_SER_DROP_CNT_EN.
module aes_out_serializer
    import aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       AES_clk,
    input  logic       AES_rst,
    input  aes_blk_t   blk_in,
    input  logic       blk_in_valid,
    output aes_word_t  ser_data,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_last,
    output logic       fifo_full,
    output logic       drop_pulse
`ifdef AES_SER_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          valid_q;
    logic [1:0]    word_idx;
    logic          cap;
    logic          xfer;
    logic          pop;
    logic          push;
    logic          at_cap;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    aes_blk_t      head;

    assign cap    = blk_in_valid & ~valid_q;
    assign at_cap = (count == CW'(DEPTH));
    assign xfer   = ser_valid & ser_ready;
    assign pop    = xfer & (word_idx == 2'd3);
    assign push   = cap & (~at_cap | pop);

    aes_blk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (AES_clk),
        .rst   (AES_rst),
        .push  (push),
        .pop   (pop),
        .wdata (blk_in),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign ser_valid = ~empty;
    assign ser_data  = ser_valid ? blk_word(head, word_idx) : '0;
    assign ser_last  = ser_valid & (word_idx == 2'd3);
    assign fifo_full = full;

    // Edge detector history for the cipher's valid strobe
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) valid_q <= 1'b0;
        else         valid_q <= blk_in_valid;
    end

    // Word position within the head block, wraps after the last word
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst)   word_idx <= 2'd0;
        else if (xfer) word_idx <= word_idx + 2'd1;
    end

    // One-cycle pulse when a captured block finds no room
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) drop_pulse <= 1'b0;
        else         drop_pulse <= cap & ~push;
    end

`ifdef AES_SER_DROP_CNT_EN
    // Saturating count of discarded blocks
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst)
            drop_cnt <= 8'd0;
        else if (cap && !push && drop_cnt != 8'hff)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Self-checking bench for aes_out_serializer (DEPTH=2).
// Table vectors, directed corner sequences and a queue-based reference model.
module tb_aes_out_serializer;
    import aes_pkg::*;

    localparam int DEPTH = 2;

    logic      clk = 1'b0;
    logic      rst;
    aes_blk_t  blk_in;
    logic      blk_in_valid;
    logic      ser_ready;
    aes_word_t ser_data;
    logic      ser_valid;
    logic      ser_last;
    logic      fifo_full;
    logic      drop_pulse;
`ifdef AES_SER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    aes_out_serializer #(
        .DEPTH (DEPTH)
    ) dut (
        .AES_clk      (clk),
        .AES_rst      (rst),
        .blk_in       (blk_in),
        .blk_in_valid (blk_in_valid),
        .ser_data     (ser_data),
        .ser_valid    (ser_valid),
        .ser_ready    (ser_ready),
        .ser_last     (ser_last),
        .fifo_full    (fifo_full),
        .drop_pulse   (drop_pulse)
`ifdef AES_SER_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nfail   = 0;

    // Reference model: queue of whole blocks plus position in the head block
    aes_blk_t mq[$];
    int       m_widx;
    bit       m_vprev;
    bit       m_full;
    bit       m_drop;
    int       m_drops;

    typedef struct {
        bit          v;
        bit          r;
        bit          exp_sv;
        logic [31:0] exp_data;
        bit          exp_last;
        bit          exp_drop;
    } vec_t;

    vec_t tbl[11];

    function automatic aes_word_t ref_word(aes_blk_t b, int i);
        return aes_word_t'(b >> (32 * (3 - i)));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_widx  = 0;
        m_vprev = 0;
        m_full  = 0;
        m_drop  = 0;
        m_drops = 0;
    endtask

    task automatic model_step(bit v, aes_blk_t b, bit r);
        bit sv, xf, pp, cp, acc;
        sv  = (mq.size() != 0);
        xf  = sv && r;
        pp  = xf && (m_widx == 3);
        cp  = v && !m_vprev;
        acc = cp && ((mq.size() < DEPTH) || pp);
        if (xf) begin
            if (pp) begin
                void'(mq.pop_front());
                m_widx = 0;
            end else begin
                m_widx++;
            end
        end
        if (acc) mq.push_back(b);
        m_drop = cp && !acc;
        if (m_drop && m_drops < 255) m_drops++;
        m_vprev = v;
        m_full  = (mq.size() == DEPTH);
    endtask

    task automatic check_model(string tag);
        bit          sv;
        logic [31:0] ed;
        sv = (mq.size() != 0);
        ed = sv ? ref_word(mq[0], m_widx) : 32'h0;
        chk({tag, ".valid"}, 32'(ser_valid), 32'(sv));
        chk({tag, ".data"}, ser_data, ed);
        chk({tag, ".last"}, 32'(ser_last), 32'(sv && m_widx == 3));
        chk({tag, ".full"}, 32'(fifo_full), 32'(m_full));
        chk({tag, ".drop"}, 32'(drop_pulse), 32'(m_drop));
`ifdef AES_SER_DROP_CNT_EN
        chk({tag, ".dcnt"}, 32'(drop_cnt), 32'(m_drops));
`endif
    endtask

    // Drive at a falling edge, advance model, check after the next rising edge
    task automatic cycle(bit v, aes_blk_t b, bit r);
        blk_in       = b;
        blk_in_valid = v;
        ser_ready    = r;
        model_step(v, b, r);
        @(negedge clk);
        check_model("mdl");
    endtask

    task automatic drain(int n, ref aes_word_t got[$]);
        for (int i = 0; i < n; i++) begin
            if (ser_valid) got.push_back(ser_data);
            cycle(0, '0, 1);
        end
    endtask

    aes_blk_t  ba, bb, bc, bd;
    aes_word_t got[$];
    int        pat[4];

    initial begin
        ba = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
        bb = 128'h00112233_44556677_8899aabb_ccddeeff;
        bc = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
        bd = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

        tbl[0]  = '{1, 1, 1, 32'h69c4e0d8, 0, 0};
        tbl[1]  = '{0, 1, 1, 32'h6a7b0430, 0, 0};
        tbl[2]  = '{0, 1, 1, 32'hd8cdb780, 0, 0};
        tbl[3]  = '{0, 1, 1, 32'h70b4c55a, 1, 0};
        tbl[4]  = '{0, 1, 0, 32'h00000000, 0, 0};
        tbl[5]  = '{1, 1, 1, 32'h69c4e0d8, 0, 0};
        tbl[6]  = '{1, 1, 1, 32'h6a7b0430, 0, 0};
        tbl[7]  = '{1, 1, 1, 32'hd8cdb780, 0, 0};
        tbl[8]  = '{1, 1, 1, 32'h70b4c55a, 1, 0};
        tbl[9]  = '{1, 1, 0, 32'h00000000, 0, 0};
        tbl[10] = '{0, 1, 0, 32'h00000000, 0, 0};

        rst          = 1'b1;
        blk_in       = '0;
        blk_in_valid = 1'b0;
        ser_ready    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.valid", 32'(ser_valid), 32'd0);
        chk("rst.data", ser_data, 32'd0);
        chk("rst.last", 32'(ser_last), 32'd0);
        chk("rst.full", 32'(fifo_full), 32'd0);
        chk("rst.drop", 32'(drop_pulse), 32'd0);
`ifdef AES_SER_DROP_CNT_EN
        chk("rst.dcnt", 32'(drop_cnt), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check_model("post_rst");

        // Single block, then held-high valid
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, ba, tbl[i].r);
            chk($sformatf("tbl%0d.valid", i), 32'(ser_valid), 32'(tbl[i].exp_sv));
            chk($sformatf("tbl%0d.data", i), ser_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d.last", i), 32'(ser_last), 32'(tbl[i].exp_last));
            chk($sformatf("tbl%0d.drop", i), 32'(drop_pulse), 32'(tbl[i].exp_drop));
        end

        // Backpressure with ready pattern 1,0,0,1
        pat = '{1, 0, 0, 1};
        cycle(1, bb, 0);
        got.delete();
        for (int i = 0; i < 16; i++) begin
            if (ser_valid && pat[i % 4] == 1) got.push_back(ser_data);
            cycle(0, '0, pat[i % 4] == 1);
        end
        chk("bp.count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("bp.w%0d", i), got[i], ref_word(bb, i));
        chk("bp.idle", 32'(ser_valid), 32'd0);

        // Overflow with the consumer stalled
        cycle(1, ba, 0);
        chk("ovf.full1", 32'(fifo_full), 32'd0);
        cycle(0, '0, 0);
        cycle(1, bb, 0);
        chk("ovf.full2", 32'(fifo_full), 32'd1);
        cycle(0, '0, 0);
        cycle(1, bc, 0);
        chk("ovf.drop3", 32'(drop_pulse), 32'd1);
`ifdef AES_SER_DROP_CNT_EN
        chk("ovf.dcnt", 32'(drop_cnt), 32'd1);
`endif
        cycle(0, '0, 0);
        chk("ovf.dropoff", 32'(drop_pulse), 32'd0);
        got.delete();
        drain(10, got);
        chk("ovf.count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("ovf.w%0d", i), got[i],
                ref_word(i < 4 ? ba : bb, i % 4));

        // Push at full coinciding with the word-3 pop
        cycle(1, ba, 0);
        cycle(0, '0, 0);
        cycle(1, bb, 0);
        cycle(0, '0, 0);
        cycle(0, '0, 1);
        cycle(0, '0, 1);
        cycle(0, '0, 1);
        chk("pf.last", 32'(ser_last), 32'd1);
        cycle(1, bc, 1);
        chk("pf.drop", 32'(drop_pulse), 32'd0);
        chk("pf.full", 32'(fifo_full), 32'd1);
        chk("pf.head", ser_data, 32'h00112233);
        got.delete();
        drain(10, got);
        chk("pf.count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("pf.w%0d", i), got[i],
                ref_word(i < 4 ? bb : bc, i % 4));

        // Reset in the middle of a block
        cycle(1, bd, 1);
        cycle(0, '0, 1);
        cycle(0, '0, 1);
        chk("mr.w2", ser_data, 32'h07060504);
        #2 rst = 1'b1;
        #1;
        chk("mr.valid", 32'(ser_valid), 32'd0);
        chk("mr.data", ser_data, 32'd0);
        model_reset();
        blk_in_valid = 1'b0;
        ser_ready    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cycle(1, ba, 1);
        chk("mr.restart", ser_data, 32'h69c4e0d8);
        chk("mr.rlast", 32'(ser_last), 32'd0);

        // Random traffic, ready mostly high
        for (int i = 0; i < 500; i++)
            cycle($urandom_range(2) == 0, {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(3) != 0);
        // Random traffic, ready mostly low to provoke drops
        for (int i = 0; i < 500; i++)
            cycle($urandom_range(1) == 0, {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(3) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
